// File: rtl/cpu6_pipeline_drain_ctrl_pkg.sv
// Shared types for the cpu6 pipeline drain sequencer.
package cpu6_pipeline_drain_ctrl_pkg;

   localparam int CPU6_DRN_W = 2;

   typedef enum logic [CPU6_DRN_W-1:0] {
      CPU6_DRN_IDLE     = 2'd0,
      CPU6_DRN_DRAIN    = 2'd1,
      CPU6_DRN_ISSUE    = 2'd2,
      CPU6_DRN_WAIT_RET = 2'd3
   } drn_state_e;

   // Hazard-unit control bundle driven to the pipeline registers.
   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic flush_d;
      logic flush_e;
      logic flush_m;
   } drn_ctl_t;

   localparam drn_ctl_t CTL_NONE     = '{stall_f: 1'b0, stall_d: 1'b0, flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0};
   localparam drn_ctl_t CTL_HOLD     = '{stall_f: 1'b1, stall_d: 1'b1, flush_d: 1'b0, flush_e: 1'b1, flush_m: 1'b0};
   localparam drn_ctl_t CTL_ISSUE    = '{stall_f: 1'b1, stall_d: 1'b0, flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0};
   localparam drn_ctl_t CTL_WAIT     = '{stall_f: 1'b1, stall_d: 1'b1, flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0};
   localparam drn_ctl_t CTL_REDIRECT = '{stall_f: 1'b0, stall_d: 1'b0, flush_d: 1'b1, flush_e: 1'b1, flush_m: 1'b1};

endpackage

// File: rtl/cpu6_pipeline_drain_ctrl_timer.sv
// Drain cycle counter with saturation and a sticky timeout flag.
module cpu6_drain_timer #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             timeout
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             hit;

   assign hit = (cnt_q == CNT_W'(TIMEOUT_CYC));

   // Next count: clear on drain start, otherwise count up and stick at all-ones.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      cnt_d = cnt_q;
      tmo_d = tmo_q | hit;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter and sticky flag registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (reset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign cnt = cnt_q;
   // The flag is visible in the same cycle the count reaches the threshold.
   assign timeout = tmo_q | hit;

endmodule

// File: rtl/cpu6_pipeline_drain_ctrl.sv
// Stall/flush sequencer: drains EX/MEM/WB ahead of pipeline-serialising
// instructions, and arbitrates drain, redirect and load-use stall.
module cpu6_pipeline_drain_ctrl
   import cpu6_pipeline_drain_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             empty_pipeline_reqD,
   input  logic             validE,
   input  logic             validM,
   input  logic             validW,
   input  logic             jumpM,
   input  logic             lwstall_req,
   input  logic             csr_retireW,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             drain_busy,
   output logic             drain_timeout,
   output logic [CNT_W-1:0] drain_cnt
);

   drn_state_e state_q, state_d;
   drn_ctl_t   ctl;
   logic       drain_start;
   logic       pipe_empty;

   assign pipe_empty = ~validE & ~validM & ~validW;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CPU6_DRN_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode; a MEM redirect overrides every FSM action.
   always_comb begin
      state_d     = state_q;
      ctl         = CTL_NONE;
      drain_start = 1'b0;
      unique case (state_q)
         CPU6_DRN_IDLE: begin
            // The serialising instruction is held in ID on its entry cycle too,
            // so it cannot slip into EX before the drain begins.
            if (empty_pipeline_reqD && !jumpM) begin
               state_d     = CPU6_DRN_DRAIN;
               drain_start = 1'b1;
               ctl         = CTL_HOLD;
            end else if (lwstall_req) begin
               ctl = CTL_HOLD;
            end
         end
         CPU6_DRN_DRAIN: begin
            ctl = CTL_HOLD;
            if (jumpM) begin
               // The instruction being drained for was on the wrong path.
               state_d = CPU6_DRN_IDLE;
            end else if (pipe_empty) begin
               state_d = CPU6_DRN_ISSUE;
            end
         end
         CPU6_DRN_ISSUE: begin
            ctl     = CTL_ISSUE;
            state_d = CPU6_DRN_WAIT_RET;
         end
         CPU6_DRN_WAIT_RET: begin
            ctl = CTL_WAIT;
            // A redirect here is a protocol error: outputs follow it, state holds.
            if (csr_retireW && !jumpM) begin
               state_d = CPU6_DRN_IDLE;
            end
         end
         default: state_d = CPU6_DRN_IDLE;
      endcase
      if (jumpM) begin
         ctl = CTL_REDIRECT;
      end
   end

   cpu6_drain_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (drain_start),
      .en      (state_q != CPU6_DRN_IDLE),
      .cnt     (drain_cnt),
      .timeout (drain_timeout)
   );

   assign stallF     = ctl.stall_f;
   assign stallD     = ctl.stall_d;
   assign flushD     = ctl.flush_d;
   assign flushE     = ctl.flush_e;
   assign flushM     = ctl.flush_m;
   assign drain_busy = (state_q != CPU6_DRN_IDLE);

endmodule

// File: tb/tb_cpu6_pipeline_drain_ctrl.sv
// Directed scoreboard bench for cpu6_pipeline_drain_ctrl.
module tb_cpu6_pipeline_drain_ctrl;

   localparam logic [4:0] O_NONE  = 5'b00000;
   localparam logic [4:0] O_HOLD  = 5'b11010;
   localparam logic [4:0] O_ISSUE = 5'b10000;
   localparam logic [4:0] O_WAIT  = 5'b11000;
   localparam logic [4:0] O_JUMP  = 5'b00111;

   logic       clk;
   logic       reset;
   logic       empty_pipeline_reqD, validE, validM, validW, jumpM, lwstall_req, csr_retireW;
   logic       stallF, stallD, flushD, flushE, flushM, drain_busy, drain_timeout;
   logic [7:0] drain_cnt;

   typedef struct {
      string      tag;
      logic       chk_out;
      logic [4:0] out;
      logic       busy;
      logic       tmo;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_pass;
   int   n_total;

   cpu6_pipeline_drain_ctrl #(.TIMEOUT_CYC(64), .CNT_W(8)) dut (
      .clk                 (clk),
      .reset               (reset),
      .empty_pipeline_reqD (empty_pipeline_reqD),
      .validE              (validE),
      .validM              (validM),
      .validW              (validW),
      .jumpM               (jumpM),
      .lwstall_req         (lwstall_req),
      .csr_retireW         (csr_retireW),
      .stallF              (stallF),
      .stallD              (stallD),
      .flushD              (flushD),
      .flushE              (flushE),
      .flushM              (flushM),
      .drain_busy          (drain_busy),
      .drain_timeout       (drain_timeout),
      .drain_cnt           (drain_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Input vector order: {reqD, validE, validM, validW, jumpM, lwstall_req, csr_retireW}
   task automatic drive(input logic [6:0] in);
      {empty_pipeline_reqD, validE, validM, validW, jumpM, lwstall_req, csr_retireW} = in;
   endtask

   task automatic expect_push(input string tag, input logic chk, input logic [4:0] eo,
                              input logic eb, input logic et, input int ec);
      exp_t e;
      e.tag = tag; e.chk_out = chk; e.out = eo; e.busy = eb; e.tmo = et; e.cnt = 8'(ec);
      sb.push_back(e);
   endtask

   task automatic compare_pop();
      exp_t       e;
      logic [4:0] obs_out;
      logic [9:0] obs_st, exp_st;
      e       = sb.pop_front();
      obs_out = {stallF, stallD, flushD, flushE, flushM};
      obs_st  = {drain_busy, drain_timeout, drain_cnt};
      exp_st  = {e.busy, e.tmo, e.cnt};
      if (e.chk_out) begin
         n_total++;
         assert (obs_out === e.out) n_pass++;
         else $error("FAIL %s ctl {sF,sD,fD,fE,fM}: got %b want %b", e.tag, obs_out, e.out);
      end
      n_total++;
      assert (obs_st === exp_st) n_pass++;
      else $error("FAIL %s status {busy,tmo,cnt}: got %b/%b/%0d want %b/%b/%0d",
                  e.tag, drain_busy, drain_timeout, drain_cnt, e.busy, e.tmo, e.cnt);
   endtask

   // One clock cycle: drive just after the rising edge, check at the falling edge.
   task automatic step(input string tag, input logic [6:0] in, input logic chk,
                       input logic [4:0] eo, input logic eb, input logic et, input int ec);
      drive(in);
      expect_push(tag, chk, eo, eb, et, ec);
      @(negedge clk);
      compare_pop();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      drive(7'b0000000);
      #3;
      expect_push("reset", 1'b1, O_NONE, 1'b0, 1'b0, 0);
      compare_pop();
      @(posedge clk);
      #1;
      reset = 1'b0;

      step("idle",          7'b0000000, 1'b1, O_NONE,  1'b0, 1'b0, 0);
      // Load-use stall in IDLE
      step("lwstall",       7'b0000010, 1'b1, O_HOLD,  1'b0, 1'b0, 0);
      step("lwstall_after", 7'b0000000, 1'b1, O_NONE,  1'b0, 1'b0, 0);

      // Full pipeline draining one stage per cycle
      step("a_entry",       7'b1111000, 1'b0, O_NONE,  1'b0, 1'b0, 0);
      step("a_drain1",      7'b1111000, 1'b1, O_HOLD,  1'b1, 1'b0, 0);
      step("a_drain2",      7'b1011000, 1'b1, O_HOLD,  1'b1, 1'b0, 1);
      step("a_drain3",      7'b1001000, 1'b1, O_HOLD,  1'b1, 1'b0, 2);
      step("a_drain4",      7'b1000000, 1'b1, O_HOLD,  1'b1, 1'b0, 3);
      step("a_issue",       7'b0000000, 1'b1, O_ISSUE, 1'b1, 1'b0, 4);
      step("a_wait",        7'b0100000, 1'b1, O_WAIT,  1'b1, 1'b0, 5);
      step("a_retire",      7'b0001001, 1'b1, O_WAIT,  1'b1, 1'b0, 6);
      step("a_idle",        7'b0000000, 1'b1, O_NONE,  1'b0, 1'b0, 7);

      // Redirect during DRAIN aborts the drain
      step("b_entry",       7'b1111000, 1'b0, O_NONE,  1'b0, 1'b0, 7);
      step("b_drain",       7'b1111000, 1'b1, O_HOLD,  1'b1, 1'b0, 0);
      step("b_drain_jump",  7'b1111100, 1'b1, O_JUMP,  1'b1, 1'b0, 1);
      step("b_after_jump",  7'b0000000, 1'b1, O_NONE,  1'b0, 1'b0, 2);
      // Redirect in IDLE blocks drain entry
      step("b_idle_jump",   7'b1000100, 1'b1, O_JUMP,  1'b0, 1'b0, 2);
      step("b_no_entry",    7'b0000000, 1'b1, O_NONE,  1'b0, 1'b0, 2);

      // Drain request with load-use stall, empty pipeline
      step("c_entry",       7'b1000010, 1'b0, O_NONE,  1'b0, 1'b0, 2);
      step("c_drain",       7'b1000010, 1'b1, O_HOLD,  1'b1, 1'b0, 0);
      step("c_issue",       7'b1000010, 1'b1, O_ISSUE, 1'b1, 1'b0, 1);
      step("c_wait_lw",     7'b0000010, 1'b1, O_WAIT,  1'b1, 1'b0, 2);
      step("c_wait_jump",   7'b0000101, 1'b1, O_JUMP,  1'b1, 1'b0, 3);
      step("c_wait_hold",   7'b0000000, 1'b1, O_WAIT,  1'b1, 1'b0, 4);

      // Retire withheld: timeout at 64, saturation at 255
      for (int c = 5; c <= 260; c++) begin
         step($sformatf("c_hold%0d", c), 7'b0000000, 1'b1, O_WAIT, 1'b1,
              (c >= 64) ? 1'b1 : 1'b0, (c > 255) ? 255 : c);
      end
      step("c_retire",      7'b0000001, 1'b1, O_WAIT,  1'b1, 1'b1, 255);
      step("c_idle",        7'b0000000, 1'b1, O_NONE,  1'b0, 1'b1, 255);

      // Sticky timeout survives a new drain, counter restarts
      step("d_entry",       7'b1000000, 1'b0, O_NONE,  1'b0, 1'b1, 255);
      step("d_drain",       7'b1000000, 1'b1, O_HOLD,  1'b1, 1'b1, 0);
      step("d_issue",       7'b0000000, 1'b1, O_ISSUE, 1'b1, 1'b1, 1);

      // Asynchronous reset in WAIT_RET
      drive(7'b0111000);
      reset = 1'b1;
      #2;
      expect_push("d_reset_async", 1'b1, O_NONE, 1'b0, 1'b0, 0);
      compare_pop();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("d_post_reset",  7'b0000000, 1'b1, O_NONE,  1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
